edge_event_arbiter: RTL and testbench
=====================================

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter: N_CH, default 4, number of monitored input channels, legal 2..8.
REQ-002 Parameter: CH_W, default 2, channel-index width, SHALL equal clog2(N_CH).
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  asynchronous, active-high; clears all state.
REQ-005 Port: en  input  N_CH  per-channel enable; 0 forces that channel idle.
REQ-006 Port: q  input  N_CH  monitored lines, synchronous to clk.
REQ-007 Port: evt_valid  output  1  event record on evt_ch/evt_rise is valid.
REQ-008 Port: evt_ready  input  1  consumer accepts the record when evt_valid=1.
REQ-009 Port: evt_ch  output  CH_W  index of the channel that produced the event.
REQ-010 Port: evt_rise  output  1  1 = 0->1 transition, 0 = 1->0 transition.
REQ-011 Port: ovf  output  N_CH  sticky per-channel lost-event flag.
REQ-012 Port: ovf_clr  input  1  clears all ovf bits at the next edge.

Function
REQ-013 Each channel SHALL run a 3-state Mealy detector: IDLE, LOW, HIGH.
REQ-014 IDLE: q=0 -> LOW, q=1 -> HIGH, no event (the first sample only establishes the level).
REQ-015 LOW: q=1 -> HIGH with a rise event; q=0 stays LOW with no event.
REQ-016 HIGH: q=0 -> LOW with a fall event; q=1 stays HIGH with no event.
REQ-017 en[i]=0 SHALL force channel i to IDLE and clear its pending bit; ovf[i] is unaffected.
REQ-018 A detected event SHALL set pend[i] and latch its polarity at the same edge at which q was sampled.
REQ-019 Event arriving while pend[i]=1 and not granted that cycle: the pending record SHALL be kept, the new event dropped, and ovf[i] set.
REQ-020 Event arriving in the cycle pend[i] is granted: the new event SHALL be captured into pend[i] with no overflow.
REQ-021 The output slot is free when evt_valid=0, or when evt_valid=1 and evt_ready=1.
REQ-022 When the slot is free and any pend bit is set, the arbiter SHALL grant one channel round-robin.
REQ-023 Search order SHALL start at (last granted + 1) mod N_CH.
REQ-024 Granting SHALL load evt_ch/evt_rise, assert evt_valid and clear that pend bit at the same edge.
REQ-025 Minimum latency: q change sampled at edge k -> evt_valid=1 after edge k+1.
REQ-026 Throughput SHALL be one event per cycle while evt_ready=1 (back-to-back refill on handshake).
REQ-027 While evt_valid=1 and evt_ready=0, evt_ch and evt_rise SHALL hold stable.
REQ-028 If ovf_clr coincides with a new overflow on channel i, ovf[i] SHALL end up set (set wins).
REQ-029 A channel disabled while its record sits in the output slot SHALL NOT retract that record.

Reset
REQ-030 reset SHALL asynchronously force all channels to IDLE, pend=0, evt_valid=0, evt_ch=0, evt_rise=0, ovf=0.
REQ-031 After reset, the round-robin pointer SHALL give channel 0 first priority.
REQ-032 Reset asserted mid-handshake SHALL discard the slot and all pending events; no event SHALL be reported for levels present at release.

Structure
REQ-033 Package edge_evt_pkg SHALL hold the state encodings IDLE=2'b00, LOW=2'b01, HIGH=2'b10 and the default N_CH.
REQ-034 Sub-module edge_chan_fsm SHALL implement one channel: detector, pending bit, polarity and ovf bit.
REQ-035 The top level SHALL instantiate N_CH copies of edge_chan_fsm and contain the arbiter and output slot.

Verification
REQ-036 Reset, en=4'hF, q=0, then q[2] 0->1 at edge 5 -> evt_valid after edge 6 with evt_ch=2, evt_rise=1.
REQ-037 All four q bits toggle in the same cycle with evt_ready=1 -> four consecutive records, channel order 0,1,2,3.
REQ-038 evt_ready=0; q[1] toggles 3 times -> one record (first edge) held stable; ovf=4'b0010; ovf_clr clears it.
REQ-039 en[3]=0 while q[3] toggles -> no record for channel 3; re-enabling with q[3]=1 -> no event until the next change.
REQ-040 reset pulse while evt_valid=1 -> evt_valid=0 immediately; q steady after release -> no events.
REQ-041 Channels 0 and 1 toggling every cycle, evt_ready=1 -> grants alternate 0,1,0,1; no ovf.

Source files
------------

// File: rtl/edge_evt_pkg.sv
// Shared constants for the edge event arbiter: channel detector encodings,
// default sizing and round-robin index arithmetic.
package edge_evt_pkg;

    localparam int N_CH_DEFAULT = 4;
    localparam int CH_W_DEFAULT = 2;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_LOW  = 2'b01;
    localparam logic [1:0] ST_HIGH = 2'b10;

    // Channel index reached by stepping ofs places from base, wrapping at n.
    function automatic int rr_index(input int base, input int ofs, input int n);
        return (base + ofs) % n;
    endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Channel inputs and the single-slot event output of the edge event arbiter.
interface edge_event_arbiter_if
    import edge_evt_pkg::*;
#(
    parameter int N_CH = N_CH_DEFAULT,
    parameter int CH_W = CH_W_DEFAULT
);
    logic [N_CH-1:0] en;
    logic [N_CH-1:0] q;
    logic [N_CH-1:0] ovf;
    logic            ovf_clr;
    logic            evt_valid;
    logic            evt_ready;
    logic [CH_W-1:0] evt_ch;
    logic            evt_rise;

    modport master (
        output en, q, ovf_clr, evt_ready,
        input  evt_valid, evt_ch, evt_rise, ovf
    );

    modport slave (
        input  en, q, ovf_clr, evt_ready,
        output evt_valid, evt_ch, evt_rise, ovf
    );
endinterface

// File: rtl/edge_chan_fsm.sv
// One monitored channel: level/edge detector, single-entry pending record
// and sticky lost-event flag.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | disabled or just out of reset; next sample sets the level
// LOW     | last sample was 0; a 1 produces a rise event
// HIGH    | last sample was 1; a 0 produces a fall event
module edge_chan_fsm
    import edge_evt_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic q,
    input  logic grant,
    input  logic ovf_clr,
    output logic pend,
    output logic pol,
    output logic ovf
);
    logic [1:0] state;
    logic       evt;
    logic       ovf_set;

    always_comb begin
        evt = 1'b0;
        if (en) begin
            case (state)
                ST_LOW:  evt = q;
                ST_HIGH: evt = ~q;
                default: evt = 1'b0;
            endcase
        end
    end

    // A grant in the same cycle frees the entry, so the new event fits.
    assign ovf_set = evt && pend && !grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            pend  <= 1'b0;
            pol   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (!en)
                state <= ST_IDLE;
            else
                state <= q ? ST_HIGH : ST_LOW;

            if (!en) begin
                pend <= 1'b0;
            end else if (evt && (!pend || grant)) begin
                pend <= 1'b1;
                pol  <= q;
            end else if (grant) begin
                pend <= 1'b0;
            end

            if (ovf_set)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end
endmodule

// File: rtl/edge_event_arbiter.sv
// Edge event arbiter: N_CH edge detectors feeding a round-robin arbiter and
// a single valid/ready output slot that refills on the accepting edge.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int N_CH = N_CH_DEFAULT,
    parameter int CH_W = CH_W_DEFAULT
) (
    input logic                 clk,
    input logic                 reset,
    edge_event_arbiter_if.slave bus
);
    logic [N_CH-1:0] pend;
    logic [N_CH-1:0] pol;
    logic [N_CH-1:0] ovf_bits;
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] grant;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] cand;
    logic [CH_W-1:0] gnt_idx;
    logic            gnt_found;
    logic            slot_free;
    logic            evt_valid_r;
    logic [CH_W-1:0] evt_ch_r;
    logic            evt_rise_r;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        edge_chan_fsm u_chan (
            .clk     (clk),
            .reset   (reset),
            .en      (bus.en[i]),
            .q       (bus.q[i]),
            .grant   (grant[i]),
            .ovf_clr (bus.ovf_clr),
            .pend    (pend[i]),
            .pol     (pol[i]),
            .ovf     (ovf_bits[i])
        );
    end

    // A disabled channel's pending bit is being cleared this edge; never grant it.
    assign req       = pend & bus.en;
    assign slot_free = !evt_valid_r || bus.evt_ready;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand = CH_W'(rr_index(int'(rr_ptr), k, N_CH));
            if (!gnt_found && req[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (slot_free && gnt_found)
            grant[gnt_idx] = 1'b1;
    end

    // rr_ptr holds the first channel to search, i.e. last granted + 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_valid_r <= 1'b0;
            evt_ch_r    <= '0;
            evt_rise_r  <= 1'b0;
            rr_ptr      <= '0;
        end else if (slot_free) begin
            if (gnt_found) begin
                evt_valid_r <= 1'b1;
                evt_ch_r    <= gnt_idx;
                evt_rise_r  <= pol[gnt_idx];
                rr_ptr      <= CH_W'(rr_index(int'(gnt_idx), 1, N_CH));
            end else begin
                evt_valid_r <= 1'b0;
            end
        end
    end

    assign bus.evt_valid = evt_valid_r;
    assign bus.evt_ch    = evt_ch_r;
    assign bus.evt_rise  = evt_rise_r;
    assign bus.ovf       = ovf_bits;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed vector bench for edge_event_arbiter (N_CH=4).
module tb_edge_event_arbiter;
    logic clk;
    logic reset;

    edge_event_arbiter_if #(.N_CH(4), .CH_W(2)) bus ();

    edge_event_arbiter #(.N_CH(4), .CH_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] en;
        logic [3:0] q;
        logic       rdy;
        logic       clr;
        logic       valid;
        logic [1:0] ch;
        logic       rise;
        logic [3:0] ovf;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] en, input logic [3:0] q, input logic rdy, input logic clr,
                       input logic valid, input logic [1:0] ch, input logic rise, input logic [3:0] ovf);
        vec_t v;
        v = '{en: en, q: q, rdy: rdy, clr: clr, valid: valid, ch: ch, rise: rise, ovf: ovf};
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset         = 1'b1;
        bus.en        = 4'hF;
        bus.q         = 4'h0;
        bus.evt_ready = 1'b1;
        bus.ovf_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
    endtask

    initial begin
        // Row: en, q, ready, ovf_clr | expected valid, ch, rise, ovf (after the edge)
        add(4'hF, 4'h0, 1, 0, 0, 0, 0, 4'h0);
        add(4'hF, 4'hF, 1, 0, 0, 0, 0, 4'h0);
        add(4'hF, 4'hF, 1, 0, 1, 0, 1, 4'h0);
        add(4'hF, 4'hF, 1, 0, 1, 1, 1, 4'h0);
        add(4'hF, 4'hF, 1, 0, 1, 2, 1, 4'h0);
        add(4'hF, 4'hF, 1, 0, 1, 3, 1, 4'h0);
        add(4'hF, 4'hF, 1, 0, 0, 0, 0, 4'h0);
        // channels 0 and 1 alternate, one event per cycle
        add(4'hF, 4'hE, 1, 0, 0, 0, 0, 4'h0);
        add(4'hF, 4'hC, 1, 0, 1, 0, 0, 4'h0);
        add(4'hF, 4'hD, 1, 0, 1, 1, 0, 4'h0);
        add(4'hF, 4'hF, 1, 0, 1, 0, 1, 4'h0);
        add(4'hF, 4'hE, 1, 0, 1, 1, 1, 4'h0);
        add(4'hF, 4'hE, 1, 0, 1, 0, 0, 4'h0);
        add(4'hF, 4'hE, 1, 0, 0, 0, 0, 4'h0);
        // stalled consumer, q[1] toggles: hold record, overflow, clear (set wins)
        add(4'hF, 4'hC, 0, 0, 0, 0, 0, 4'h0);
        add(4'hF, 4'hE, 0, 0, 1, 1, 0, 4'h0);
        add(4'hF, 4'hC, 0, 0, 1, 1, 0, 4'h2);
        add(4'hF, 4'hC, 0, 0, 1, 1, 0, 4'h2);
        add(4'hF, 4'hE, 0, 1, 1, 1, 0, 4'h2);
        add(4'hF, 4'hE, 0, 1, 1, 1, 0, 4'h0);
        add(4'hF, 4'hE, 1, 0, 1, 1, 1, 4'h0);
        add(4'hF, 4'hE, 1, 0, 0, 0, 0, 4'h0);
        // channel 3 disabled while toggling, then re-enabled high
        add(4'h7, 4'hE, 1, 0, 0, 0, 0, 4'h0);
        add(4'h7, 4'h6, 1, 0, 0, 0, 0, 4'h0);
        add(4'h7, 4'hE, 1, 0, 0, 0, 0, 4'h0);
        add(4'h7, 4'h6, 1, 0, 0, 0, 0, 4'h0);
        add(4'h7, 4'hE, 1, 0, 0, 0, 0, 4'h0);
        add(4'hF, 4'hE, 1, 0, 0, 0, 0, 4'h0);
        add(4'hF, 4'hE, 1, 0, 0, 0, 0, 4'h0);
        add(4'hF, 4'h6, 1, 0, 0, 0, 0, 4'h0);
        add(4'hF, 4'h6, 1, 0, 1, 3, 0, 4'h0);
        add(4'hF, 4'h6, 1, 0, 0, 0, 0, 4'h0);
        // disabling a channel whose record is in the slot keeps the record
        add(4'hF, 4'h7, 1, 0, 0, 0, 0, 4'h0);
        add(4'hF, 4'h7, 0, 0, 1, 0, 1, 4'h0);
        add(4'hE, 4'h7, 0, 0, 1, 0, 1, 4'h0);
        add(4'hE, 4'h7, 1, 0, 0, 0, 0, 4'h0);

        // Reset state, then q[2] rises at edge 5
        apply_reset();
        check("rst_valid", 32'(bus.evt_valid), 32'd0);
        check("rst_ch",    32'(bus.evt_ch),    32'd0);
        check("rst_rise",  32'(bus.evt_rise),  32'd0);
        check("rst_ovf",   32'(bus.ovf),       32'd0);
        repeat (4) tick();
        bus.q = 4'h4;
        tick();
        check("lat_edge5_valid", 32'(bus.evt_valid), 32'd0);
        tick();
        check("lat_edge6_valid", 32'(bus.evt_valid), 32'd1);
        check("lat_edge6_ch",    32'(bus.evt_ch),    32'd2);
        check("lat_edge6_rise",  32'(bus.evt_rise),  32'd1);

        // Vector table from a fresh reset
        apply_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            bus.en        = vecs[i].en;
            bus.q         = vecs[i].q;
            bus.evt_ready = vecs[i].rdy;
            bus.ovf_clr   = vecs[i].clr;
            tick();
            check($sformatf("vec%0d_valid", i), 32'(bus.evt_valid), 32'(vecs[i].valid));
            if (vecs[i].valid) begin
                check($sformatf("vec%0d_ch", i),   32'(bus.evt_ch),   32'(vecs[i].ch));
                check($sformatf("vec%0d_rise", i), 32'(bus.evt_rise), 32'(vecs[i].rise));
            end
            check($sformatf("vec%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].ovf));
        end

        // Reset pulse while a record sits in the slot
        bus.en        = 4'hF;
        bus.q         = 4'h7;
        bus.evt_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        tick();
        bus.q = 4'h3;
        tick();
        tick();
        check("midrst_pre_valid", 32'(bus.evt_valid), 32'd1);
        check("midrst_pre_ch",    32'(bus.evt_ch),    32'd2);
        #2 reset = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.evt_valid), 32'd0);
        check("midrst_ch",    32'(bus.evt_ch),    32'd0);
        bus.q = 4'h6;
        bus.evt_ready = 1'b1;
        @(posedge clk);
        #3 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("postrst_valid%0d", i), 32'(bus.evt_valid), 32'd0);
        end
        check("postrst_ovf", 32'(bus.ovf), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
